// File: rtl/issue_scoreboard.sv
// Issue-stage hazard scoreboard for a dual-issue pipeline: gates slot issue on load/mul bubbles
// and a single outstanding divide. Optional perf counters are enabled by SCOREBOARD_PERF_EN.
module issue_scoreboard #(
  parameter int unsigned NREG      = 32,
  parameter int unsigned LD_BUBBLE = 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        flush_i,
  input  logic        pipe_stall_i,
  input  logic        in_valid0_i,
  input  logic        in_valid1_i,
  input  logic [4:0]  eu0_rj_i,
  input  logic [4:0]  eu0_rk_i,
  input  logic [4:0]  eu0_rd_i,
  input  logic [4:0]  eu1_rj_i,
  input  logic [4:0]  eu1_rk_i,
  input  logic [4:0]  eu1_rd_i,
  input  logic        eu0_we_i,
  input  logic        eu1_we_i,
  input  logic [1:0]  eu0_cls_i,
  input  logic [1:0]  eu1_cls_i,
  input  logic        div_done_i,
  output logic        issue_fire0_o,
  output logic        issue_fire1_o,
  output logic        div_busy_o,
  output logic        div_cancel_o
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_split_cnt_o
`endif
);

  localparam int unsigned CntW = (LD_BUBBLE < 2) ? 1 : $clog2(LD_BUBBLE + 1);
  localparam logic [CntW-1:0] LdSet = CntW'(LD_BUBBLE);
  localparam logic [1:0] ClsLdMul = 2'd1;
  localparam logic [1:0] ClsDiv   = 2'd2;

  typedef enum logic {StIdle, StBusy} div_st_e;

  div_st_e         div_st_q, div_st_d;
  logic [4:0]      div_rd_q, div_rd_d;
  logic [CntW-1:0] cnt_q [NREG];
  logic [CntW-1:0] cnt_d [NREG];

  logic            busy;
  logic [NREG-1:0] pend_vec;
  logic            hz0, hz1, raw01, struct01, waw01;
  logic            fire0, fire1;
  logic            heavy0, heavy1;
  logic            wr0, wr1;

  assign busy = (div_st_q == StBusy);

  assign pend_vec[0] = 1'b0;
  for (genvar g = 1; g < NREG; g++) begin : g_pend
    assign pend_vec[g] = (cnt_q[g] != '0) || (busy && (div_rd_q == 5'(g)));
  end

  assign hz0 = pend_vec[eu0_rj_i] || pend_vec[eu0_rk_i] ||
               (eu0_we_i && (eu0_rd_i != 5'd0) && busy && (eu0_rd_i == div_rd_q)) ||
               ((eu0_cls_i == ClsDiv) && busy);
  assign hz1 = pend_vec[eu1_rj_i] || pend_vec[eu1_rk_i] ||
               (eu1_we_i && (eu1_rd_i != 5'd0) && busy && (eu1_rd_i == div_rd_q)) ||
               ((eu1_cls_i == ClsDiv) && busy);

  assign heavy0   = (eu0_cls_i == ClsLdMul) || (eu0_cls_i == ClsDiv);
  assign heavy1   = (eu1_cls_i == ClsLdMul) || (eu1_cls_i == ClsDiv);
  assign raw01    = eu0_we_i && (eu0_rd_i != 5'd0) &&
                    ((eu1_rj_i == eu0_rd_i) || (eu1_rk_i == eu0_rd_i));
  assign struct01 = heavy0 && heavy1;
  // Pair WAW only matters when slot 0 is the late (exe2) producer.
  assign waw01    = (eu0_cls_i == ClsLdMul) && eu0_we_i && eu1_we_i &&
                    (eu0_rd_i == eu1_rd_i) && (eu0_rd_i != 5'd0);

  assign fire0 = in_valid0_i && !hz0 && !pipe_stall_i && !flush_i;
  assign fire1 = fire0 && in_valid1_i && !hz1 && !raw01 && !struct01 && !waw01;

  assign issue_fire0_o = fire0;
  assign issue_fire1_o = fire1;
  assign div_busy_o    = busy;
  assign div_cancel_o  = flush_i && busy;

  assign wr0 = fire0 && eu0_we_i && (eu0_rd_i != 5'd0) && (eu0_cls_i != ClsDiv);
  assign wr1 = fire1 && eu1_we_i && (eu1_rd_i != 5'd0) && (eu1_cls_i != ClsDiv);

  // Slot 1 writes last so it wins on a shared rd.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      for (int i = 0; i < int'(NREG); i++) cnt_d[i] = '0;
    end else if (!pipe_stall_i) begin
      for (int i = 1; i < int'(NREG); i++) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CntW'(1);
      end
      if (wr0) cnt_d[eu0_rd_i] = (eu0_cls_i == ClsLdMul) ? LdSet : '0;
      if (wr1) cnt_d[eu1_rd_i] = (eu1_cls_i == ClsLdMul) ? LdSet : '0;
    end
  end

  always_comb begin
    div_st_d = div_st_q;
    div_rd_d = div_rd_q;
    if (flush_i) begin
      div_st_d = StIdle;
    end else if (busy) begin
      if (div_done_i) div_st_d = StIdle;
    end else if (fire0 && (eu0_cls_i == ClsDiv)) begin
      div_st_d = StBusy;
      div_rd_d = eu0_we_i ? eu0_rd_i : 5'd0;
    end else if (fire1 && (eu1_cls_i == ClsDiv)) begin
      div_st_d = StBusy;
      div_rd_d = eu1_we_i ? eu1_rd_i : 5'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(NREG); i++) cnt_q[i] <= '0;
      div_st_q <= StIdle;
      div_rd_q <= 5'd0;
    end else begin
      cnt_q    <= cnt_d;
      div_st_q <= div_st_d;
      div_rd_q <= div_rd_d;
    end
  end

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_q, split_cnt_q;
  logic        stall_inc, split_inc;

  assign stall_inc = in_valid0_i && !fire0 && !pipe_stall_i && !flush_i;
  assign split_inc = fire0 && in_valid1_i && !fire1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stall_cnt_q <= '0;
      split_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (split_inc && (split_cnt_q != '1)) split_cnt_q <= split_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_split_cnt_o = split_cnt_q;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized plus directed bench for issue_scoreboard; a register-readiness model in virtual
// time predicts each cycle's outputs, which a decoupled monitor compares.
module tb_issue_scoreboard;

  localparam int LdBubble = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, flush, pipe_stall, in_valid0, in_valid1;
  logic [4:0] eu0_rj, eu0_rk, eu0_rd, eu1_rj, eu1_rk, eu1_rd;
  logic       eu0_we, eu1_we;
  logic [1:0] eu0_cls, eu1_cls;
  logic       div_done;
  logic       issue_fire0, issue_fire1, div_busy, div_cancel;
`ifdef SCOREBOARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_split_cnt;
`endif

  issue_scoreboard #(.NREG(32), .LD_BUBBLE(LdBubble)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .flush_i      (flush),
    .pipe_stall_i (pipe_stall),
    .in_valid0_i  (in_valid0),
    .in_valid1_i  (in_valid1),
    .eu0_rj_i     (eu0_rj),
    .eu0_rk_i     (eu0_rk),
    .eu0_rd_i     (eu0_rd),
    .eu1_rj_i     (eu1_rj),
    .eu1_rk_i     (eu1_rk),
    .eu1_rd_i     (eu1_rd),
    .eu0_we_i     (eu0_we),
    .eu1_we_i     (eu1_we),
    .eu0_cls_i    (eu0_cls),
    .eu1_cls_i    (eu1_cls),
    .div_done_i   (div_done),
    .issue_fire0_o(issue_fire0),
    .issue_fire1_o(issue_fire1),
    .div_busy_o   (div_busy),
    .div_cancel_o (div_cancel)
`ifdef SCOREBOARD_PERF_EN
    ,
    .perf_stall_cnt_o(perf_stall_cnt),
    .perf_split_cnt_o(perf_split_cnt)
`endif
  );

  typedef struct packed {
    logic       v0, v1;
    logic [4:0] rj0, rk0, rd0, rj1, rk1, rd1;
    logic       we0, we1;
    logic [1:0] c0, c1;
    logic       flush, stall, done;
  } stim_t;

  typedef struct packed {
    logic        f0, f1, busy, cancel;
    logic [31:0] stall_cnt, split_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   stim_done = 1'b0;

  // Reference model: a register is readable once virtual time (non-stalled cycles) reaches it.
  int          ready_vt [32];
  int          vt = 0;
  bit          m_busy = 1'b0;
  logic [4:0]  m_div_rd = 5'd0;
  logic [31:0] m_stall_cnt = 32'd0;
  logic [31:0] m_split_cnt = 32'd0;

  function automatic logic mpend(input logic [4:0] r);
    return (r != 5'd0) && ((ready_vt[r] > vt) || (m_busy && (r == m_div_rd)));
  endfunction

  function automatic logic mhaz(input logic [4:0] rj, input logic [4:0] rk, input logic [4:0] rd,
                                input logic we, input logic [1:0] c);
    return mpend(rj) || mpend(rk) || (we && (rd != 5'd0) && m_busy && (rd == m_div_rd)) ||
           ((c == 2'd2) && m_busy);
  endfunction

  function automatic logic heavy(input logic [1:0] c);
    return (c == 2'd1) || (c == 2'd2);
  endfunction

  function automatic exp_t model_eval(input stim_t s);
    exp_t e;
    e.f0 = s.v0 && !mhaz(s.rj0, s.rk0, s.rd0, s.we0, s.c0) && !s.stall && !s.flush;
    e.f1 = e.f0 && s.v1 && !mhaz(s.rj1, s.rk1, s.rd1, s.we1, s.c1) &&
           !(s.we0 && (s.rd0 != 5'd0) && ((s.rj1 == s.rd0) || (s.rk1 == s.rd0))) &&
           !(heavy(s.c0) && heavy(s.c1)) &&
           !((s.c0 == 2'd1) && s.we0 && s.we1 && (s.rd0 == s.rd1) && (s.rd0 != 5'd0));
    e.busy      = m_busy;
    e.cancel    = s.flush && m_busy;
    e.stall_cnt = m_stall_cnt;
    e.split_cnt = m_split_cnt;
    return e;
  endfunction

  task automatic retire(input logic [4:0] rd, input logic we, input logic [1:0] c);
    if (c == 2'd2) begin
      m_busy   = 1'b1;
      m_div_rd = we ? rd : 5'd0;
    end else if (we && (rd != 5'd0)) begin
      ready_vt[rd] = (c == 2'd1) ? vt + LdBubble + 1 : 0;
    end
  endtask

  task automatic model_step(input stim_t s, input exp_t e);
    if (s.v0 && !e.f0 && !s.stall && !s.flush) m_stall_cnt = m_stall_cnt + 32'd1;
    if (e.f0 && s.v1 && !e.f1) m_split_cnt = m_split_cnt + 32'd1;
    if (s.flush) begin
      foreach (ready_vt[i]) ready_vt[i] = 0;
      m_busy = 1'b0;
    end else begin
      if (m_busy && s.done) m_busy = 1'b0;
      if (!s.stall) begin
        if (e.f0) retire(s.rd0, s.we0, s.c0);
        if (e.f1) retire(s.rd1, s.we1, s.c1);
        vt++;
      end
    end
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    @(negedge clk);
    in_valid0 = s.v0;  in_valid1 = s.v1;
    eu0_rj = s.rj0;  eu0_rk = s.rk0;  eu0_rd = s.rd0;
    eu1_rj = s.rj1;  eu1_rk = s.rk1;  eu1_rd = s.rd1;
    eu0_we = s.we0;  eu1_we = s.we1;  eu0_cls = s.c0;  eu1_cls = s.c1;
    flush = s.flush;  pipe_stall = s.stall;  div_done = s.done;
    e = model_eval(s);
    exp_q.push_back(e);
    model_step(s, e);
  endtask

  function automatic stim_t alu0(input logic [4:0] rj);
    stim_t s = '0;
    s.v0 = 1'b1;
    s.rj0 = rj;
    return s;
  endfunction

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.v0 = ($urandom_range(0, 9) < 8);
    s.v1 = ($urandom_range(0, 9) < 7);
    s.rj0 = rreg();  s.rk0 = rreg();  s.rd0 = rreg();
    s.rj1 = rreg();  s.rk1 = rreg();  s.rd1 = rreg();
    s.we0 = ($urandom_range(0, 3) != 0);
    s.we1 = ($urandom_range(0, 3) != 0);
    s.c0 = 2'($urandom_range(0, 3));
    s.c1 = 2'($urandom_range(0, 3));
    s.flush = ($urandom_range(0, 24) == 0);
    s.stall = ($urandom_range(0, 9) == 0);
    s.done  = m_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
    return s;
  endfunction

  // Stimulus
  initial begin
    stim_t s;
    foreach (ready_vt[i]) ready_vt[i] = 0;
    rstn = 1'b0;  flush = 1'b0;  pipe_stall = 1'b0;  in_valid0 = 1'b0;  in_valid1 = 1'b0;
    eu0_rj = '0;  eu0_rk = '0;  eu0_rd = '0;  eu1_rj = '0;  eu1_rk = '0;  eu1_rd = '0;
    eu0_we = 1'b0;  eu1_we = 1'b0;  eu0_cls = '0;  eu1_cls = '0;  div_done = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Load-use
    s = '0; s.v0 = 1; s.c0 = 2'd1; s.we0 = 1; s.rd0 = 5'd5; drive(s);
    drive(alu0(5'd5));
    drive(alu0(5'd5));
    // Intra-pair RAW
    s = '0; s.v0 = 1; s.we0 = 1; s.rd0 = 5'd3; s.v1 = 1; s.rj1 = 5'd3; drive(s);
    drive(alu0(5'd3));
    // Divide: consumer and second DIV blocked until done
    s = '0; s.v0 = 1; s.c0 = 2'd2; s.we0 = 1; s.rd0 = 5'd7; drive(s);
    for (int i = 0; i < 10; i++) drive(alu0(5'd7));
    s = '0; s.v0 = 1; s.c0 = 2'd2; s.we0 = 1; s.rd0 = 5'd8; drive(s); drive(s);
    s = alu0(5'd7); s.done = 1; drive(s);
    drive(alu0(5'd7));
    s = '0; s.v0 = 1; s.c0 = 2'd2; s.we0 = 1; s.rd0 = 5'd8; drive(s);
    s = '0; s.done = 1; drive(s);
    // Flush mid-divide
    s = '0; s.v0 = 1; s.c0 = 2'd2; s.we0 = 1; s.rd0 = 5'd7; drive(s);
    s = '0; s.v0 = 1; s.c0 = 2'd1; s.we0 = 1; s.rd0 = 5'd9; drive(s);
    s = alu0(5'd9); s.flush = 1; drive(s);
    s = alu0(5'd9); s.v1 = 1; s.rj1 = 5'd7; drive(s);
    // pipe_stall freeze
    s = '0; s.v0 = 1; s.c0 = 2'd1; s.we0 = 1; s.rd0 = 5'd4; drive(s);
    for (int i = 0; i < 3; i++) begin s = alu0(5'd4); s.stall = 1; drive(s); end
    drive(alu0(5'd4));
    drive(alu0(5'd4));
    // r0 and same-rd pair
    s = '0; s.v0 = 1; s.c0 = 2'd1; s.we0 = 1; s.rd0 = 5'd0; s.v1 = 1; s.rj1 = 5'd0; drive(s);
    s = '0; s.v0 = 1; s.c0 = 2'd1; s.we0 = 1; s.rd0 = 5'd6;
    s.v1 = 1; s.we1 = 1; s.rd1 = 5'd6; s.rj1 = 5'd1; drive(s);
    drive('0);

    for (int i = 0; i < 3000; i++) drive(rand_stim());
    stim_done = 1'b1;
  end

  // Monitor
  initial begin
    exp_t e;
    int   cyc = 0;
    #3;
    n_tests++;
    if ({issue_fire0, issue_fire1, div_busy, div_cancel} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset fire0/fire1/busy/cancel got %b%b%b%b want 0000",
               issue_fire0, issue_fire1, div_busy, div_cancel);
    end
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({issue_fire0, issue_fire1, div_busy, div_cancel} !== {e.f0, e.f1, e.busy, e.cancel})
        begin
          n_fail++;
          $display("FAIL cyc%0d fire0/fire1/busy/cancel got %b%b%b%b want %b%b%b%b", cyc,
                   issue_fire0, issue_fire1, div_busy, div_cancel, e.f0, e.f1, e.busy, e.cancel);
        end
`ifdef SCOREBOARD_PERF_EN
        n_tests++;
        if ({perf_stall_cnt, perf_split_cnt} !== {e.stall_cnt, e.split_cnt}) begin
          n_fail++;
          $display("FAIL cyc%0d perf stall/split got %0d/%0d want %0d/%0d", cyc,
                   perf_stall_cnt, perf_split_cnt, e.stall_cnt, e.split_cnt);
        end
`endif
      end else if (stim_done) begin
        break;
      end
      if (cyc > 8000) begin
        n_fail++;
        $display("FAIL watchdog cycles got %0d want <= 8000", cyc);
        break;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
